// File: rtl/writeback_arbiter.sv
// Purpose: merges in-order pipeline writebacks and a one-entry buffered aux result onto one register-file write port, with a busy scoreboard.
// Latency: pipe writes pass through combinationally; an aux result accepted in cycle N can be written in N+1 at the earliest.
// Backpressure: auxWriteReady drops while the hold entry is full; pipeStall holds the pipe while a starved aux entry preempts it.
module writeback_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipeWriteValid,
    input  logic [4:0]  pipeWriteIndex,
    input  logic [31:0] pipeWriteData,
    input  logic        auxWriteValid,
    input  logic [4:0]  auxWriteIndex,
    input  logic [31:0] auxWriteData,
    output logic        auxWriteReady,
    input  logic        auxIssueValid,
    input  logic [4:0]  auxIssueIndex,
    input  logic [4:0]  queryIndex1,
    input  logic [4:0]  queryIndex2,
    output logic        queryBusy1,
    output logic        queryBusy2,
    output logic        shouldWrite,
    output logic [4:0]  writeRegisterIndex,
    output logic [31:0] writeRegisterData,
    output logic        pipeStall
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {
        MODE_NORMAL  = 1'b0,
        MODE_PREEMPT = 1'b1
    } mode_e;

    logic        hold_vld_q, hold_vld_d;
    logic [4:0]  hold_idx_q, hold_idx_d;
    logic [31:0] hold_dat_q, hold_dat_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] busy_q, busy_d;

    mode_e mode;
    logic  pipe_req;
    logic  grant_pipe;
    logic  grant_hold;
    logic  aux_acc;

    always_comb begin
        mode = (hold_vld_q && wait_cnt_q == LIMIT) ? MODE_PREEMPT : MODE_NORMAL;
        // Reset gating keeps the write port quiet while reset is held low.
        pipe_req   = reset && pipeWriteValid && (pipeWriteIndex != 5'd0);
        grant_pipe = pipe_req && (mode == MODE_NORMAL);
        grant_hold = hold_vld_q && !grant_pipe;
        aux_acc    = auxWriteValid && !hold_vld_q;

        auxWriteReady      = !hold_vld_q;
        pipeStall          = pipe_req && (mode == MODE_PREEMPT);
        shouldWrite        = 1'b0;
        writeRegisterIndex = 5'd0;
        writeRegisterData  = 32'd0;
        if (grant_pipe) begin
            shouldWrite        = 1'b1;
            writeRegisterIndex = pipeWriteIndex;
            writeRegisterData  = pipeWriteData;
        end else if (grant_hold) begin
            shouldWrite        = 1'b1;
            writeRegisterIndex = hold_idx_q;
            writeRegisterData  = hold_dat_q;
        end

        queryBusy1 = (queryIndex1 != 5'd0) && busy_q[queryIndex1];
        queryBusy2 = (queryIndex2 != 5'd0) && busy_q[queryIndex2];
    end

    always_comb begin
        hold_vld_d = hold_vld_q;
        hold_idx_d = hold_idx_q;
        hold_dat_d = hold_dat_q;
        wait_cnt_d = wait_cnt_q;
        busy_d     = busy_q;

        if (grant_hold) begin
            hold_vld_d         = 1'b0;
            wait_cnt_d         = 4'd0;
            busy_d[hold_idx_q] = 1'b0;
        end else if (hold_vld_q && wait_cnt_q != LIMIT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        // Accept only happens with an empty hold entry, so it never overlaps a hold grant.
        if (aux_acc && auxWriteIndex != 5'd0) begin
            hold_vld_d = 1'b1;
            hold_idx_d = auxWriteIndex;
            hold_dat_d = auxWriteData;
            wait_cnt_d = 4'd0;
        end

        // Applied last so a newer issue wins over the retiring entry's clear.
        if (auxIssueValid && auxIssueIndex != 5'd0) begin
            busy_d[auxIssueIndex] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_vld_q <= 1'b0;
            hold_idx_q <= 5'd0;
            hold_dat_q <= 32'd0;
            wait_cnt_q <= 4'd0;
            busy_q     <= 32'd0;
        end else begin
            hold_vld_q <= hold_vld_d;
            hold_idx_q <= hold_idx_d;
            hold_dat_q <= hold_dat_d;
            wait_cnt_q <= wait_cnt_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: scoreboard of expected register-file writes plus per-scenario cycle checks.
module tb_writeback_arbiter;

    logic        clk;
    logic        reset;
    logic        pipeWriteValid;
    logic [4:0]  pipeWriteIndex;
    logic [31:0] pipeWriteData;
    logic        auxWriteValid;
    logic [4:0]  auxWriteIndex;
    logic [31:0] auxWriteData;
    logic        auxWriteReady;
    logic        auxIssueValid;
    logic [4:0]  auxIssueIndex;
    logic [4:0]  queryIndex1;
    logic [4:0]  queryIndex2;
    logic        queryBusy1;
    logic        queryBusy2;
    logic        shouldWrite;
    logic [4:0]  writeRegisterIndex;
    logic [31:0] writeRegisterData;
    logic        pipeStall;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] dat;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    writeback_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk                (clk),
        .reset              (reset),
        .pipeWriteValid     (pipeWriteValid),
        .pipeWriteIndex     (pipeWriteIndex),
        .pipeWriteData      (pipeWriteData),
        .auxWriteValid      (auxWriteValid),
        .auxWriteIndex      (auxWriteIndex),
        .auxWriteData       (auxWriteData),
        .auxWriteReady      (auxWriteReady),
        .auxIssueValid      (auxIssueValid),
        .auxIssueIndex      (auxIssueIndex),
        .queryIndex1        (queryIndex1),
        .queryIndex2        (queryIndex2),
        .queryBusy1         (queryBusy1),
        .queryBusy2         (queryBusy2),
        .shouldWrite        (shouldWrite),
        .writeRegisterIndex (writeRegisterIndex),
        .writeRegisterData  (writeRegisterData),
        .pipeStall          (pipeStall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every write seen on the port must match the oldest expected write.
    always @(negedge clk) begin
        if (reset === 1'b1 && shouldWrite !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got idx %0d data %h, expected none", writeRegisterIndex, writeRegisterData);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (writeRegisterIndex !== e.idx || writeRegisterData !== e.dat) begin
                    errors++;
                    $display("FAIL write_port: got idx %0d data %h, expected idx %0d data %h",
                             writeRegisterIndex, writeRegisterData, e.idx, e.dat);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pipeWriteValid = 1'b0;
        pipeWriteIndex = 5'd0;
        pipeWriteData  = 32'd0;
        auxWriteValid  = 1'b0;
        auxWriteIndex  = 5'd0;
        auxWriteData   = 32'd0;
        auxIssueValid  = 1'b0;
        auxIssueIndex  = 5'd0;
    endtask

    task automatic test_reset();
        clear_inputs();
        queryIndex1    = 5'd3;
        queryIndex2    = 5'd5;
        reset          = 1'b0;
        pipeWriteValid = 1'b1;
        pipeWriteIndex = 5'd3;
        pipeWriteData  = 32'h1111_2222;
        @(negedge clk);
        checks++;
        if (auxWriteReady !== 1'b1 || shouldWrite !== 1'b0 || writeRegisterIndex !== 5'd0 ||
            writeRegisterData !== 32'd0 || pipeStall !== 1'b0 || queryBusy1 !== 1'b0 || queryBusy2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy %b wr %b idx %0d data %h stall %b busy %b%b, expected 1 0 0 0 0 00",
                     auxWriteReady, shouldWrite, writeRegisterIndex, writeRegisterData, pipeStall, queryBusy1, queryBusy2);
        end
        step();
        clear_inputs();
        reset = 1'b1;
        step();
    endtask

    task automatic test_aux_write();
        auxIssueValid = 1'b1;
        auxIssueIndex = 5'd5;
        queryIndex1   = 5'd5;
        step();
        auxIssueValid = 1'b0;
        auxWriteValid = 1'b1;
        auxWriteIndex = 5'd5;
        auxWriteData  = 32'hDEAD_BEEF;
        exp_q.push_back('{idx: 5'd5, dat: 32'hDEAD_BEEF});
        @(negedge clk);
        checks++;
        if (auxWriteReady !== 1'b1 || queryBusy1 !== 1'b1 || shouldWrite !== 1'b0) begin
            errors++;
            $display("FAIL aux_accept: got rdy %b busy %b wr %b, expected 1 1 0", auxWriteReady, queryBusy1, shouldWrite);
        end
        step();
        auxWriteValid = 1'b0;
        @(negedge clk);
        checks++;
        if (auxWriteReady !== 1'b0 || shouldWrite !== 1'b1 || queryBusy1 !== 1'b1) begin
            errors++;
            $display("FAIL aux_grant: got rdy %b wr %b busy %b, expected 0 1 1", auxWriteReady, shouldWrite, queryBusy1);
        end
        step();
        @(negedge clk);
        checks++;
        if (auxWriteReady !== 1'b1 || queryBusy1 !== 1'b0 || shouldWrite !== 1'b0) begin
            errors++;
            $display("FAIL aux_after: got rdy %b busy %b wr %b, expected 1 0 0", auxWriteReady, queryBusy1, shouldWrite);
        end
        step();
    endtask

    task automatic test_starvation();
        logic [31:0] pdat;
        for (int cyc = 0; cyc < 6; cyc++) begin
            // The stalled pipe write (cycle 4) is held stable and lands in cycle 5.
            pdat = (cyc == 5) ? 32'h0000_0304 : (32'h0000_0300 + 32'(cyc));
            pipeWriteValid = 1'b1;
            pipeWriteIndex = 5'd3;
            pipeWriteData  = pdat;
            auxWriteValid  = (cyc == 0);
            auxWriteIndex  = 5'd7;
            auxWriteData   = 32'h7777_0007;
            if (cyc == 4) exp_q.push_back('{idx: 5'd7, dat: 32'h7777_0007});
            else          exp_q.push_back('{idx: 5'd3, dat: pdat});
            @(negedge clk);
            checks++;
            if (pipeStall !== (cyc == 4) || shouldWrite !== 1'b1) begin
                errors++;
                $display("FAIL starve_stall_c%0d: got stall %b wr %b, expected %b 1", cyc, pipeStall, shouldWrite, (cyc == 4));
            end
            checks++;
            if (auxWriteReady !== (cyc == 0 || cyc == 5)) begin
                errors++;
                $display("FAIL starve_ready_c%0d: got %b, expected %b", cyc, auxWriteReady, (cyc == 0 || cyc == 5));
            end
            step();
        end
        clear_inputs();
        step();
    endtask

    task automatic test_busy();
        queryIndex1   = 5'd9;
        queryIndex2   = 5'd0;
        auxIssueValid = 1'b1;
        auxIssueIndex = 5'd9;
        step();
        auxIssueValid = 1'b0;
        auxWriteValid = 1'b1;
        auxWriteIndex = 5'd9;
        auxWriteData  = 32'h0000_0099;
        exp_q.push_back('{idx: 5'd9, dat: 32'h0000_0099});
        @(negedge clk);
        checks++;
        if (queryBusy1 !== 1'b1 || queryBusy2 !== 1'b0) begin
            errors++;
            $display("FAIL busy_set: got %b %b, expected 1 0", queryBusy1, queryBusy2);
        end
        step();
        auxWriteValid = 1'b0;
        @(negedge clk);
        checks++;
        if (queryBusy1 !== 1'b1 || shouldWrite !== 1'b1) begin
            errors++;
            $display("FAIL busy_grant_cycle: got busy %b wr %b, expected 1 1", queryBusy1, shouldWrite);
        end
        step();
        auxWriteValid = 1'b1;
        auxWriteData  = 32'h0000_009A;
        exp_q.push_back('{idx: 5'd9, dat: 32'h0000_009A});
        @(negedge clk);
        checks++;
        if (queryBusy1 !== 1'b0) begin
            errors++;
            $display("FAIL busy_cleared: got %b, expected 0", queryBusy1);
        end
        step();
        auxWriteValid = 1'b0;
        auxIssueValid = 1'b1;
        auxIssueIndex = 5'd9;
        @(negedge clk);
        checks++;
        if (shouldWrite !== 1'b1 || queryBusy1 !== 1'b0) begin
            errors++;
            $display("FAIL busy_reissue_grant: got wr %b busy %b, expected 1 0", shouldWrite, queryBusy1);
        end
        step();
        auxIssueValid = 1'b0;
        queryIndex2   = 5'd9;
        @(negedge clk);
        checks++;
        if (queryBusy1 !== 1'b1 || queryBusy2 !== 1'b1) begin
            errors++;
            $display("FAIL busy_newer_wins: got %b %b, expected 1 1", queryBusy1, queryBusy2);
        end
        step();
    endtask

    task automatic test_reg_zero();
        pipeWriteValid = 1'b1;
        pipeWriteIndex = 5'd0;
        pipeWriteData  = 32'h0000_0123;
        auxWriteValid  = 1'b1;
        auxWriteIndex  = 5'd0;
        auxWriteData   = 32'h0000_0456;
        @(negedge clk);
        checks++;
        if (shouldWrite !== 1'b0 || auxWriteReady !== 1'b1) begin
            errors++;
            $display("FAIL zero_same_cycle: got wr %b rdy %b, expected 0 1", shouldWrite, auxWriteReady);
        end
        step();
        auxWriteValid = 1'b0;
        @(negedge clk);
        checks++;
        if (shouldWrite !== 1'b0 || auxWriteReady !== 1'b1) begin
            errors++;
            $display("FAIL zero_next_cycle: got wr %b rdy %b, expected 0 1", shouldWrite, auxWriteReady);
        end
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        queryIndex1    = 5'd12;
        queryIndex2    = 5'd0;
        auxIssueValid  = 1'b1;
        auxIssueIndex  = 5'd12;
        pipeWriteValid = 1'b1;
        pipeWriteIndex = 5'd4;
        pipeWriteData  = 32'h0000_0400;
        exp_q.push_back('{idx: 5'd4, dat: 32'h0000_0400});
        step();
        auxIssueValid  = 1'b0;
        auxWriteValid  = 1'b1;
        auxWriteIndex  = 5'd12;
        auxWriteData   = 32'h0C0C_0C0C;
        pipeWriteData  = 32'h0000_0401;
        exp_q.push_back('{idx: 5'd4, dat: 32'h0000_0401});
        step();
        auxWriteValid  = 1'b0;
        pipeWriteData  = 32'h0000_0402;
        exp_q.push_back('{idx: 5'd4, dat: 32'h0000_0402});
        @(negedge clk);
        checks++;
        if (auxWriteReady !== 1'b0 || queryBusy1 !== 1'b1 || pipeStall !== 1'b0) begin
            errors++;
            $display("FAIL rst_pending: got rdy %b busy %b stall %b, expected 0 1 0", auxWriteReady, queryBusy1, pipeStall);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (auxWriteReady !== 1'b1 || queryBusy1 !== 1'b0 || shouldWrite !== 1'b0 || pipeStall !== 1'b0) begin
            errors++;
            $display("FAIL rst_immediate: got rdy %b busy %b wr %b stall %b, expected 1 0 0 0",
                     auxWriteReady, queryBusy1, shouldWrite, pipeStall);
        end
        step();
        clear_inputs();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (shouldWrite !== 1'b0 || queryBusy1 !== 1'b0 || auxWriteReady !== 1'b1) begin
                errors++;
                $display("FAIL rst_dropped_c%0d: got wr %b busy %b rdy %b, expected 0 0 1", i, shouldWrite, queryBusy1, auxWriteReady);
            end
            step();
        end
    endtask

    initial begin
        clear_inputs();
        reset       = 1'b0;
        queryIndex1 = 5'd0;
        queryIndex2 = 5'd0;
        #1;
        test_reset();
        test_aux_write();
        test_starvation();
        test_busy();
        test_reg_zero();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d writes outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 3: cycles a buffered aux write may be deferred before it preempts the pipeline (legal range 1-15).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have ports pipeWriteValid / pipeWriteIndex / pipeWriteData  input  1/5/32  in-order pipeline writeback request.
REQ-006 The block SHALL have ports auxWriteValid / auxWriteIndex / auxWriteData  input  1/5/32  multi-cycle unit result.
REQ-007 The block SHALL have port auxWriteReady  output  1  aux result accepted when high with auxWriteValid.
REQ-008 The block SHALL have ports auxIssueValid / auxIssueIndex  input  1/5  multi-cycle op issued with this destination.
REQ-009 The block SHALL have ports queryIndex1 / queryIndex2  input  5/5 and queryBusy1 / queryBusy2  output  1/1  scoreboard lookup.
REQ-010 The block SHALL have ports shouldWrite / writeRegisterIndex / writeRegisterData  output  1/5/32  drive the register file write port.
REQ-011 The block SHALL have port pipeStall  output  1  pipeline must hold its writeback stable this cycle.

Function
REQ-012 The block SHALL hold one aux entry (holdValid, holdIndex, holdData), a wait counter waitCount (0..STARVE_LIMIT, saturating) and a 32-bit busy vector.
REQ-013 The block SHALL drive auxWriteReady = !holdValid; an aux handshake with index != 0 loads the hold entry at the edge; with index 0 it is consumed and discarded.
REQ-014 The block SHALL treat pipeWriteValid with pipeWriteIndex 0 as no request.
REQ-015 The block SHALL be in PREEMPT when holdValid && waitCount == STARVE_LIMIT, else NORMAL.
REQ-016 In NORMAL the block SHALL grant a valid pipe request; otherwise it SHALL grant the hold entry if holdValid.
REQ-017 In PREEMPT the block SHALL grant the hold entry and assert pipeStall = pipeWriteValid && pipeWriteIndex != 0 (combinational, same cycle).
REQ-018 The block SHALL drive write-port outputs combinationally from the granted source; with no grant shouldWrite=0, index=0, data=0.
REQ-019 The block SHALL clear holdValid and waitCount at the edge the hold entry is granted; a new aux handshake is possible the next cycle (aux latency: accept cycle N, earliest write N+1).
REQ-020 The block SHALL increment waitCount when holdValid and not granted, saturating at STARVE_LIMIT.
REQ-021 The block SHALL set busy[auxIssueIndex] on auxIssueValid (index != 0) and clear busy[holdIndex] when the hold entry is granted.
REQ-022 On simultaneous set and clear of the same index the block SHALL apply set (newer op wins).
REQ-023 The block SHALL drive queryBusyN = busy[queryIndexN], and 0 for index 0; query reflects state before the current edge (no bypass).
REQ-024 The block SHALL never write register 0 and never issue two writes in one cycle.

Reset
REQ-025 While reset is low the block SHALL clear holdValid, waitCount and busy; outputs auxWriteReady=1, shouldWrite=0, writeRegisterIndex=0, writeRegisterData=0, pipeStall=0, queryBusy=0.
REQ-026 Assertion mid-operation SHALL drop any buffered aux write without writing it; deassertion takes effect at the next rising edge.

Verification
REQ-027 The bench SHALL apply aux write x5=0xDEADBEEF with no pipe traffic -> auxWriteReady falls next cycle; shouldWrite=1, index 5, data 0xDEADBEEF that cycle; busy[5] cleared after.
REQ-028 The bench SHALL apply aux hold x7 with continuous pipe writes x3 and STARVE_LIMIT=3 -> pipe granted 3 cycles, 4th cycle x7 written with pipeStall=1, pipe write to x3 lands next cycle.
REQ-029 The bench SHALL apply auxIssue x9, then query x9 -> queryBusy=1 until the cycle after the x9 hold entry is written; issue x9 in the grant cycle -> busy stays 1.
REQ-030 The bench SHALL apply pipe write x0 and aux write x0 -> shouldWrite stays 0, aux consumed (auxWriteReady stays 1).
REQ-031 The bench SHALL assert reset with hold x12 pending and busy[12]=1 -> entry never written, busy[12]=0, auxWriteReady=1 immediately.
